// File: rtl/ieeedrv_pkg.sv
// Shared definitions for the IEEE drive subsystem: phase generator state
// encoding and the ROM time-multiplexer slot spacing it must honour.
package ieeedrv_pkg;

  // Phase generator FSM states.
  typedef enum logic [1:0] {
    RUN_LO = 2'd0,
    RUN_HI = 2'd1,
    PAUSED = 2'd2
  } phgen_state_t;

  // Clocks the ROM mux needs between two ph2 pulses to finish its slot walk.
  localparam int unsigned IEEEDRV_ROMMUX_MIN_GAP = 32'd8;

  // Accumulator increment in Hz: two half-phases per CPU cycle, doubled in turbo.
  function automatic int unsigned phgen_step_hz(input logic turbo_i,
                                                input int unsigned cpu_hz_i);
    if (turbo_i) begin
      return 32'd4 * cpu_hz_i;
    end else begin
      return 32'd2 * cpu_hz_i;
    end
  endfunction

endpackage

// File: rtl/ieeedrv_frac_div.sv
// Fractional clock divider: adds step_i every enabled clock and fires ev_o
// whenever the running sum reaches mod_i, keeping the remainder so the long
// term event rate is exactly step_i/mod_i of the clock.
module ieeedrv_frac_div #(
  parameter int unsigned ACC_W = 32'd26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] step_i,
  input  logic [ACC_W-1:0] mod_i,
  output logic             ev_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum_s;

  // Sum and event detection; kept apart from the next-state logic so the
  // clear path that depends on ev_o does not form a loop through this block.
  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, step_i};
    if (en_i && (sum_s >= {1'b0, mod_i})) begin
      ev_o = 1'b1;
    end else begin
      ev_o = 1'b0;
    end
  end

  // Next accumulator value: clear wins, otherwise wrap on event or accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (!en_i) begin
      acc_d = acc_q;
    end else if (ev_o) begin
      acc_d = sum_s[ACC_W-1:0] - mod_i;
    end else begin
      acc_d = sum_s[ACC_W-1:0];
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ieeedrv_phgen_chk.sv
// Simulation-only protocol checks on the phase strobes: ph1/ph2 exclusive
// and ph2 pulses spaced far enough apart for the ROM mux.
module ieeedrv_phgen_chk #(
  parameter int unsigned MIN_GAP = 32'd8
) (
  input logic clk,
  input logic reset_n,
  input logic ph1_i,
  input logic ph2_i
);

  logic [15:0] gap_q;
  logic        seen_q;

  // Clocks elapsed since the most recent ph2 (saturating), and whether one occurred.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gap_q  <= 16'd0;
      seen_q <= 1'b0;
    end else if (ph2_i) begin
      gap_q  <= 16'd1;
      seen_q <= 1'b1;
    end else if (gap_q != 16'hFFFF) begin
      gap_q  <= gap_q + 16'd1;
    end else begin
      gap_q  <= gap_q;
    end
  end

  a_ph_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(ph1_i && ph2_i));

  a_ph2_min_gap: assert property (@(posedge clk) disable iff (!reset_n)
    (ph2_i && seen_q) |-> (gap_q >= 16'(MIN_GAP)));

endmodule

// File: rtl/ieeedrv_phgen.sv
// Drive-CPU phase generator: turns the system clock into ph1/ph2 strobes and
// the phi2 level at an exact long-term CPU rate, with pause/ack for host
// image access and a turbo (double rate) mode latched at ph2 boundaries.
module ieeedrv_phgen
  import ieeedrv_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 32'd32000000,
  parameter int unsigned CPU_HZ  = 32'd1000000,
  parameter int unsigned ACC_W   = 32'd26,
  parameter int unsigned MIN_GAP = IEEEDRV_ROMMUX_MIN_GAP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        turbo,
  input  logic        pause_req,
  output logic        pause_ack,
  output logic        ph1,
  output logic        ph2,
  output logic        phi2_lvl,
  output logic [31:0] cyc_cnt
);

  localparam logic [ACC_W-1:0] MOD_HZ  = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] STEP_LO = ACC_W'(phgen_step_hz(1'b0, CPU_HZ));
  localparam logic [ACC_W-1:0] STEP_HI = ACC_W'(phgen_step_hz(1'b1, CPU_HZ));

  // Turbo ph2 spacing must still leave the ROM mux its full slot sequence,
  // and the accumulator must hold the largest transient sum.
  if ((CLK_HZ / (32'd4 * CPU_HZ)) < (MIN_GAP / 32'd2)) begin : g_gap_too_small
    $fatal(1, "ieeedrv_phgen: CLK_HZ/CPU_HZ ratio too small for MIN_GAP");
  end
  if ((64'd1 << ACC_W) <= (64'(CLK_HZ) + 64'd4 * 64'(CPU_HZ))) begin : g_acc_too_narrow
    $fatal(1, "ieeedrv_phgen: ACC_W too narrow for CLK_HZ + 4*CPU_HZ");
  end

  phgen_state_t     state_q, state_d;
  logic             turbo_q, turbo_d;
  logic             ph1_q, ph1_d;
  logic             ph2_q, ph2_d;
  logic             phi2_q, phi2_d;
  logic             ack_q, ack_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             ev_s;
  logic             en_s;
  logic             clr_s;
  logic [ACC_W-1:0] step_s;

  // The divider runs except while halted; entering a pause restarts it from
  // zero so the resume half-period is a clean full length.
  assign en_s   = (state_q != PAUSED);
  assign step_s = turbo_q ? STEP_HI : STEP_LO;
  assign clr_s  = (state_q == RUN_HI) && ev_s && pause_req;

  ieeedrv_frac_div #(
    .ACC_W (ACC_W)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en_s),
    .clr_i   (clr_s),
    .step_i  (step_s),
    .mod_i   (MOD_HZ),
    .ev_o    (ev_s)
  );

  // Phase FSM next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    turbo_d = turbo_q;
    ph1_d   = 1'b0;
    ph2_d   = 1'b0;
    phi2_d  = phi2_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN_LO: begin
        if (ev_s) begin
          ph1_d   = 1'b1;
          phi2_d  = 1'b0;
          state_d = RUN_HI;
        end else begin
          state_d = RUN_LO;
        end
      end
      RUN_HI: begin
        if (ev_s) begin
          ph2_d   = 1'b1;
          phi2_d  = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          turbo_d = turbo;
          if (pause_req) begin
            ack_d   = 1'b1;
            state_d = PAUSED;
          end else begin
            state_d = RUN_LO;
          end
        end else begin
          state_d = RUN_HI;
        end
      end
      PAUSED: begin
        if (!pause_req) begin
          ack_d   = 1'b0;
          state_d = RUN_LO;
        end else begin
          state_d = PAUSED;
        end
      end
      default: begin
        state_d = RUN_LO;
      end
    endcase
  end

  // State and output registers; reset overrides any half-cycle or pause.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN_LO;
      turbo_q <= 1'b0;
      ph1_q   <= 1'b0;
      ph2_q   <= 1'b0;
      phi2_q  <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      turbo_q <= turbo_d;
      ph1_q   <= ph1_d;
      ph2_q   <= ph2_d;
      phi2_q  <= phi2_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ph1       = ph1_q;
  assign ph2       = ph2_q;
  assign phi2_lvl  = phi2_q;
  assign pause_ack = ack_q;
  assign cyc_cnt   = cnt_q;

  ieeedrv_phgen_chk #(
    .MIN_GAP (MIN_GAP)
  ) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .ph1_i   (ph1_q),
    .ph2_i   (ph2_q)
  );

endmodule

// File: tb/tb_ieeedrv_phgen.sv
// Bench for ieeedrv_phgen: expected ph1/ph2 pulses (edge index and cyc_cnt)
// are queued by the stimulus and consumed by a monitor on every pulse.
module tb_ieeedrv_phgen;

  logic        clk = 1'b0;
  logic        reset_n, turbo, pause_req;
  logic        pause_ack, ph1, ph2, phi2_lvl;
  logic [31:0] cyc_cnt;

  logic        reset_b_n, turbo_b, pause_req_b;
  logic        pause_ack_b, ph1_b, ph2_b, phi2_lvl_b;
  logic [31:0] cyc_cnt_b;

  int unsigned edge_n = 0;
  int          tests  = 0;
  int          fails  = 0;

  typedef struct {
    bit          is_ph2;
    int unsigned at;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Rising edges seen so far; read at the falling edge.
  always @(posedge clk) edge_n <= edge_n + 1;

  ieeedrv_phgen u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .turbo     (turbo),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
    .ph1       (ph1),
    .ph2       (ph2),
    .phi2_lvl  (phi2_lvl),
    .cyc_cnt   (cyc_cnt)
  );

  ieeedrv_phgen #(
    .CLK_HZ (32'd31500000)
  ) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_b_n),
    .turbo     (turbo_b),
    .pause_req (pause_req_b),
    .pause_ack (pause_ack_b),
    .ph1       (ph1_b),
    .ph2       (ph2_b),
    .phi2_lvl  (phi2_lvl_b),
    .cyc_cnt   (cyc_cnt_b)
  );

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (ph1 || ph2) begin
      exp_t e;
      tests++;
      if (ph1 && ph2) begin
        fails++;
        $display("FAIL ph_overlap: ph1 and ph2 both high at edge %0d", edge_n);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: ph2=%0d at edge %0d cyc_cnt=%0d, none expected",
                 ph2, edge_n, cyc_cnt);
      end else begin
        e = exp_q.pop_front();
        if ((e.is_ph2 != ph2) || (e.at != edge_n) || (e.cnt != cyc_cnt)) begin
          fails++;
          $display("FAIL pulse: got ph2=%0d edge=%0d cnt=%0d, expected ph2=%0d edge=%0d cnt=%0d",
                   ph2, edge_n, cyc_cnt, e.is_ph2, e.at, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic wait_edge(input int unsigned n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic push(input bit is_ph2, input int unsigned at, input logic [31:0] cnt);
    exp_t e;
    e.is_ph2 = is_ph2;
    e.at     = at;
    e.cnt    = cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(output int unsigned rel);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rel = edge_n;
  endtask

  task automatic check_idle(input string name);
    check({name, "_ph1"}, {31'd0, ph1}, 32'd0);
    check({name, "_ph2"}, {31'd0, ph2}, 32'd0);
    check({name, "_phi2"}, {31'd0, phi2_lvl}, 32'd0);
    check({name, "_ack"}, {31'd0, pause_ack}, 32'd0);
    check({name, "_cnt"}, cyc_cnt, 32'd0);
  endtask

  initial begin
    int unsigned rel;
    int unsigned last;
    int unsigned bad;
    bit          first;

    reset_n     = 1'b0;
    turbo       = 1'b0;
    pause_req   = 1'b0;
    reset_b_n   = 1'b0;
    turbo_b     = 1'b0;
    pause_req_b = 1'b0;

    // Basic cadence at default rates.
    do_reset(rel);
    check_idle("reset");
    push(1'b0, rel + 16, 32'd0);
    push(1'b1, rel + 32, 32'd1);
    push(1'b0, rel + 48, 32'd1);
    push(1'b1, rel + 64, 32'd2);
    wait_edge(rel + 31); check("phi2_before", {31'd0, phi2_lvl}, 32'd0);
    wait_edge(rel + 32); check("phi2_rise", {31'd0, phi2_lvl}, 32'd1);
    check("cnt_first", cyc_cnt, 32'd1);
    wait_edge(rel + 47); check("phi2_hold", {31'd0, phi2_lvl}, 32'd1);
    wait_edge(rel + 48); check("phi2_fall", {31'd0, phi2_lvl}, 32'd0);
    wait_edge(rel + 70); check("drain_basic", exp_q.size(), 32'd0);

    // Turbo from reset takes effect after the first ph2; mid-RUN_LO drop
    // only changes the period after the following ph2.
    turbo = 1'b1;
    do_reset(rel);
    push(1'b0, rel + 16, 32'd0);  push(1'b1, rel + 32, 32'd1);
    push(1'b0, rel + 40, 32'd1);  push(1'b1, rel + 48, 32'd2);
    push(1'b0, rel + 56, 32'd2);  push(1'b1, rel + 64, 32'd3);
    push(1'b0, rel + 72, 32'd3);  push(1'b1, rel + 80, 32'd4);
    push(1'b0, rel + 96, 32'd4);  push(1'b1, rel + 112, 32'd5);
    wait_edge(rel + 68);
    turbo = 1'b0;
    wait_edge(rel + 114); check("drain_turbo", exp_q.size(), 32'd0);

    // Pause requested mid-RUN_LO: cycle completes, then halts until dropped.
    do_reset(rel);
    push(1'b0, rel + 16, 32'd0);
    push(1'b1, rel + 32, 32'd1);
    wait_edge(rel + 5);
    pause_req = 1'b1;
    wait_edge(rel + 31); check("ack_pre", {31'd0, pause_ack}, 32'd0);
    wait_edge(rel + 32); check("ack_set", {31'd0, pause_ack}, 32'd1);
    wait_edge(rel + 132);
    check("ack_held", {31'd0, pause_ack}, 32'd1);
    check("phi2_paused", {31'd0, phi2_lvl}, 32'd1);
    check("cnt_paused", cyc_cnt, 32'd1);
    pause_req = 1'b0;
    push(1'b0, rel + 149, 32'd1);
    push(1'b1, rel + 165, 32'd2);
    wait_edge(rel + 133); check("ack_clear", {31'd0, pause_ack}, 32'd0);
    wait_edge(rel + 166); check("drain_pause", exp_q.size(), 32'd0);

    // A short pause_req pulse away from the ph2 boundary is ignored.
    do_reset(rel);
    push(1'b0, rel + 16, 32'd0);  push(1'b1, rel + 32, 32'd1);
    push(1'b0, rel + 48, 32'd1);  push(1'b1, rel + 64, 32'd2);
    wait_edge(rel + 4);
    pause_req = 1'b1;
    wait_edge(rel + 7);
    pause_req = 1'b0;
    wait_edge(rel + 33); check("ack_brief", {31'd0, pause_ack}, 32'd0);
    wait_edge(rel + 70); check("drain_brief", exp_q.size(), 32'd0);

    // One-clock reset while PAUSED, then normal restart cadence.
    pause_req = 1'b1;
    do_reset(rel);
    push(1'b0, rel + 16, 32'd0);
    push(1'b1, rel + 32, 32'd1);
    wait_edge(rel + 40);
    check("ack_before_rst", {31'd0, pause_ack}, 32'd1);
    reset_n   = 1'b0;
    pause_req = 1'b0;
    wait_edge(rel + 41);
    reset_n = 1'b1;
    check_idle("rst_paused");
    rel = edge_n;
    push(1'b0, rel + 16, 32'd0);  push(1'b1, rel + 32, 32'd1);
    push(1'b0, rel + 48, 32'd1);
    wait_edge(rel + 50); check("drain_rst_paused", exp_q.size(), 32'd0);

    // Reset on the clock that detects the ph1 event: no pulse escapes.
    do_reset(rel);
    wait_edge(rel + 15);
    reset_n = 1'b0;
    wait_edge(rel + 16);
    reset_n = 1'b1;
    check_idle("rst_event");
    rel = edge_n;
    push(1'b0, rel + 16, 32'd0);  push(1'b1, rel + 32, 32'd1);
    // Reset in the clock right after a ph1 pulse.
    wait_edge(rel + 40);
    reset_n = 1'b0;
    wait_edge(rel + 41);
    reset_n = 1'b1;
    check_idle("rst_after");
    rel = edge_n;
    push(1'b0, rel + 16, 32'd0);  push(1'b1, rel + 32, 32'd1);
    wait_edge(rel + 40); check("drain_rst_event", exp_q.size(), 32'd0);

    // Non-integer ratio: 31.5 MHz for 1000 CPU cycles.
    reset_n = 1'b0;
    @(negedge clk);
    reset_b_n = 1'b1;
    rel   = edge_n;
    last  = 0;
    bad   = 0;
    first = 1'b1;
    while ((cyc_cnt_b < 32'd1000) && (edge_n < rel + 40000)) begin
      @(negedge clk);
      if (ph2_b) begin
        if (!first && ((edge_n - last) != 31) && ((edge_n - last) != 32)) bad++;
        first = 1'b0;
        last  = edge_n;
      end
    end
    check("frac_cycles", cyc_cnt_b, 32'd1000);
    check("frac_clocks", last - rel, 32'd31500);
    check("frac_gaps_bad", bad, 32'd0);

    check("drain_final", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
